oled_frame_streamer: RTL and testbench
======================================

# oled_frame_streamer

- Drives the 96x64 RGB565 PmodOLEDrgb (SSD1331) over 4-wire SPI.
- Each frame it scans `pix_index` across the display, samples the 16-bit `pixel_data` returned by the overlay renderers, and shifts it out MSB-first.
- Each frame is preceded by a column/row address-window command burst.
- It is the initiator for the pixel-renderer interface and sits between the renderer mux and the OLED Pmod pins.

## Interface

Parameters:
- `WIDTH`, 96, display columns
- `HEIGHT`, 64, display rows
- `SCLK_DIV`, 1, `clk` cycles per SCLK half-period (≥1)
- `GAP_CYCLES`, 16, `clk` cycles `cs_n` stays high between frames

Ports:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `enable` in 1: level; frames stream while high
- `pixel_data` in 16: RGB565 from renderer for the current `pix_index`; renderers register their output, so it is valid ≥1 `clk` after `pix_index` changes
- `pix_index` out 13: pixel index for the renderers, x = idx % WIDTH, y = idx / WIDTH
- `frame_begin` out 1: one-cycle pulse on entry to pixel phase
- `sending_pixels` out 1: high throughout pixel phase
- `busy` out 1: high in any state except IDLE
- `cs_n` out 1: SPI chip select, active low
- `sclk` out 1: SPI clock, mode 3 (idle high)
- `sdin` out 1: SPI data
- `dc` out 1: 0 = command byte, 1 = pixel data

## Operation

States: IDLE, CMD, PIX, GAP.

- **IDLE**
  - `cs_n`=1, `sclk`=1, `sdin`=0, `dc`=0, `pix_index`=0.
  - `enable`=1 → CMD next cycle.
- **CMD**
  - `cs_n`=0, `dc`=0.
  - Sends six bytes MSB-first: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1.
  - `pix_index` held at 0 throughout, so pixel 0 is settled before PIX.
  - After the last bit → PIX.
- **PIX**
  - `dc`=1, `sending_pixels`=1. `frame_begin` pulses on the first PIX cycle.
  - At each word load (first cycle of word n): shift register ← `pixel_data`, which belongs to the index n presented since the previous load; in the same cycle `pix_index` ← n+1.
  - So the renderers get a full word time (32·SCLK_DIV cycles) to settle.
  - After word WIDTH·HEIGHT−1 (6143) is shifted, `pix_index` wraps to 0 → GAP.
- **GAP**
  - `cs_n`=1, `sclk`=1.
  - Counts GAP_CYCLES, then goes to CMD if `enable`=1, else IDLE.
- **Bit timing**
  - `sdin` changes on SCLK falling edge; it is stable across the rising edge.
  - Each bit is SCLK_DIV cycles low followed by SCLK_DIV cycles high.
- **Boundaries**
  - `enable` dropping mid-frame: the current frame completes, then GAP → IDLE. Frames are never truncated.
  - `enable` toggling inside GAP: only the value on the final GAP cycle matters.
  - `reset` in any state: next cycle all outputs take their IDLE values, bit/word counters clear, and a partial frame is abandoned.
- **Widths**
  - Pixel counter is 13 bits, compared against WIDTH·HEIGHT−1.
  - Bit counter is 4 bits; byte counter is 3 bits.
  - The SCLK divider counter is sized by $clog2(SCLK_DIV)+1.

## Timing

- Reset values:
  - `cs_n`=1, `sclk`=1, `sdin`=0, `dc`=0
  - `pix_index`=0, `frame_begin`=0, `sending_pixels`=0, `busy`=0
- `enable` rise to first `cs_n` fall: 1 cycle. `cs_n` falls together with the first SCLK low half.
- CMD phase: 48·2·SCLK_DIV cycles (96 at SCLK_DIV=1).
- PIX phase: 6144·16·2·SCLK_DIV cycles (196608 at SCLK_DIV=1).
- Frame period with continuous `enable`: CMD + PIX + GAP_CYCLES = 196720 cycles at defaults.
- `pix_index` changes exactly once per word, on the load cycle.

## Structure

- Shared package `oled_pkg`:
  - OLED_W=96, OLED_H=64, OLED_PIXELS=6144
  - SSD1331 opcodes CMD_SET_COL=0x15 and CMD_SET_ROW=0x75
  - state enum
- Sub-module `spi_shifter`:
  - 16-bit parallel-load, MSB-first, mode-3 shifter with SCLK_DIV.
  - Inputs `load`, `len8`, `data[15:0]`; outputs `done`, `sclk`, `sdin`.
  - Command bytes load as `{byte, 8'h00}` with `len8`=1.
- Top level holds the FSM, byte/pixel counters and command ROM.

## Test plan

1. **Reset and idle:** `reset` for 3 cycles, `enable`=0 → all outputs at reset values, `busy`=0 for 100 cycles.
2. **Command burst:** `enable`=1 → bus model decodes dc=0 bytes 0x15,0x00,0x5F,0x75,0x00,0x3F, then `frame_begin` pulses once, exactly 96 cycles after `cs_n` fell.
3. **Pixel ordering:** renderer model returns `pixel_data`=`pix_index` registered one cycle late → decoded words are 0,1,…,6143 in order, none duplicated or skipped, then `cs_n`=1 for 16 cycles.
4. **Disable mid-frame:** drop `enable` at pixel 3000 → all 6144 words still sent, then IDLE. No further `cs_n` fall.
5. **Reset mid-pixel:** assert `reset` during bit 7 of word 100 → next cycle `cs_n`=1, `sclk`=1, `pix_index`=0. A new `enable` restarts with a full command burst.
6. **Divider check:** SCLK_DIV=3, back-to-back frames → SCLK high/low halves of 3 cycles, frame period 590128 cycles, `sdin` stable across every rising SCLK edge.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_pkg
// Description : Shared constants, FSM state type and the address-window
//               command ROM for the SSD1331 (PmodOLEDrgb) frame streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

    localparam int OLED_W      = 96;
    localparam int OLED_H      = 64;
    localparam int OLED_PIXELS = OLED_W * OLED_H;

    // SSD1331 opcodes
    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;

    // Index of the final byte of the six-byte address-window burst
    localparam logic [2:0] CMD_LAST = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_PIX  = 2'd2,
        ST_GAP  = 2'd3
    } oled_state_t;

    // Address-window burst: column 0..col_end, then row 0..row_end
    function automatic logic [7:0] cmd_rom(input logic [2:0] idx,
                                           input logic [7:0] col_end,
                                           input logic [7:0] row_end);
        case (idx)
            3'd0:    cmd_rom = CMD_SET_COL;
            3'd2:    cmd_rom = col_end;
            3'd3:    cmd_rom = CMD_SET_ROW;
            3'd5:    cmd_rom = row_end;
            default: cmd_rom = 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_shifter
// Description : 16-bit parallel-load, MSB-first SPI mode-3 shifter.
//               Each bit is SCLK_DIV cycles low then SCLK_DIV cycles high;
//               sdin only changes at the start of a low half.
//               Ports: load/len8/data start a transfer (len8 sends data[15:8]
//               only); done is high on the final cycle of the last bit so a
//               new load in that cycle continues without a bubble.
//               sclk idles high, sdin idles low.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shifter #(
    parameter int SCLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        len8,
    input  logic [15:0] data,
    output logic        done,
    output logic        sclk,
    output logic        sdin
);

    localparam int                 c_DIV_W    = $clog2(SCLK_DIV) + 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCLK_DIV - 1);

    logic               r_active;
    logic               r_high;
    logic [15:0]        r_sr;
    logic [3:0]         r_bits;
    logic [c_DIV_W-1:0] r_div;
    logic               w_div_end;

    assign w_div_end = (r_div == c_DIV_LAST);
    assign done      = r_active & r_high & w_div_end & (r_bits == 4'd0);
    assign sclk      = ~r_active | r_high;
    assign sdin      = r_active & r_sr[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_high   <= 1'b0;
            r_sr     <= '0;
            r_bits   <= '0;
            r_div    <= '0;
        end else if (load) begin
            r_active <= 1'b1;
            r_high   <= 1'b0;
            r_sr     <= data;
            r_bits   <= len8 ? 4'd7 : 4'd15;
            r_div    <= '0;
        end else if (r_active) begin
            if (!w_div_end) begin
                r_div <= r_div + c_DIV_W'(1);
            end else begin
                r_div <= '0;
                if (!r_high) begin
                    r_high <= 1'b1;
                end else if (r_bits == 4'd0) begin
                    // last bit finished and nothing queued: release the bus
                    r_active <= 1'b0;
                    r_high   <= 1'b0;
                end else begin
                    r_high <= 1'b0;
                    r_sr   <= {r_sr[14:0], 1'b0};
                    r_bits <= r_bits - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/oled_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : oled_frame_streamer
// Description : Streams RGB565 frames to an SSD1331 96x64 OLED over 4-wire
//               SPI. Each frame: six-byte address-window command burst
//               (dc=0), then WIDTH*HEIGHT pixel words (dc=1), then a
//               GAP_CYCLES chip-select-high gap.
//               Ports: enable (level) starts/continues frames; pix_index
//               drives the renderers, pixel_data returns their colour;
//               frame_begin/sending_pixels/busy report progress;
//               cs_n/sclk/sdin/dc are the Pmod pins.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int WIDTH      = OLED_W,
    parameter int HEIGHT     = OLED_H,
    parameter int SCLK_DIV   = 1,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [12:0] pix_index,
    output logic        frame_begin,
    output logic        sending_pixels,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        sdin,
    output logic        dc
);

    localparam int                 c_GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [12:0]        c_PIX_LAST = 13'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]         c_COL_END  = 8'(WIDTH - 1);
    localparam logic [7:0]         c_ROW_END  = 8'(HEIGHT - 1);

    oled_state_t        r_state;
    oled_state_t        w_next;
    logic [2:0]         r_byte;
    logic [c_GAP_W-1:0] r_gap;
    logic [12:0]        r_pix;
    logic               r_frame_begin;

    logic               w_load;
    logic               w_len8;
    logic [15:0]        w_load_data;
    logic               w_done;
    logic               w_pix_step;

    spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .len8  (w_len8),
        .data  (w_load_data),
        .done  (w_done),
        .sclk  (sclk),
        .sdin  (sdin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_byte        <= '0;
            r_gap         <= '0;
            r_pix         <= '0;
            r_frame_begin <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_frame_begin <= (r_state == ST_CMD) && (w_next == ST_PIX);
            if (r_state != ST_CMD) begin
                r_byte <= '0;
            end else if (w_done) begin
                r_byte <= r_byte + 3'd1;
            end
            if (r_state != ST_GAP) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + c_GAP_W'(1);
            end
            // pix_index moves only when a pixel word is loaded; the index of
            // the word just loaded plus one is presented for the next load.
            if (w_pix_step) begin
                r_pix <= (r_pix == c_PIX_LAST) ? 13'd0 : r_pix + 13'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_len8      = 1'b0;
        w_load_data = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next      = ST_CMD;
                    w_load      = 1'b1;
                    w_len8      = 1'b1;
                    w_load_data = {cmd_rom(3'd0, c_COL_END, c_ROW_END), 8'h00};
                end
            end
            ST_CMD: begin
                if (w_done) begin
                    w_load = 1'b1;
                    if (r_byte == CMD_LAST) begin
                        w_next      = ST_PIX;
                        w_load_data = pixel_data;
                    end else begin
                        w_len8      = 1'b1;
                        w_load_data = {cmd_rom(r_byte + 3'd1, c_COL_END, c_ROW_END), 8'h00};
                    end
                end
            end
            ST_PIX: begin
                // pix_index has wrapped to 0 only while the last word shifts
                if (w_done) begin
                    if (r_pix == 13'd0) begin
                        w_next = ST_GAP;
                    end else begin
                        w_load      = 1'b1;
                        w_load_data = pixel_data;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    if (enable) begin
                        w_next      = ST_CMD;
                        w_load      = 1'b1;
                        w_len8      = 1'b1;
                        w_load_data = {cmd_rom(3'd0, c_COL_END, c_ROW_END), 8'h00};
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_pix_step     = w_load & ~w_len8;
    assign pix_index      = r_pix;
    assign frame_begin    = r_frame_begin;
    assign sending_pixels = (r_state == ST_PIX);
    assign dc             = (r_state == ST_PIX);
    assign busy           = (r_state != ST_IDLE);
    assign cs_n           = ~((r_state == ST_CMD) || (r_state == ST_PIX));

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_frame_streamer
// Description : Self-checking bench. DUT A uses default parameters, DUT B a
//               small 8x4 display with SCLK_DIV=3. A frame-position model
//               predicts every output per cycle; an SPI decoder rebuilds the
//               byte/word stream for literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_frame_streamer;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        en  [2];
    logic [15:0] pdat[2];
    logic [12:0] pidx[2];
    logic        fb  [2];
    logic        sp  [2];
    logic        bsy [2];
    logic        csn [2];
    logic        sck [2];
    logic        sdi [2];
    logic        dcs [2];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    bit m_run[2];
    int m_t  [2];

    // decoder / monitor state
    logic [16:0] dq0[$];
    logic [16:0] dq1[$];
    int          fall_a;
    int          fall_b[$];
    int          frames[2];
    int          nb[2];
    logic [15:0] sh[2];
    logic        psck[2];
    logic        psdi[2];
    logic        pcsn[2];

    always #5 clk = ~clk;

    oled_frame_streamer u_dut_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .pixel_data(pdat[0]),
        .pix_index(pidx[0]), .frame_begin(fb[0]), .sending_pixels(sp[0]),
        .busy(bsy[0]), .cs_n(csn[0]), .sclk(sck[0]), .sdin(sdi[0]), .dc(dcs[0])
    );

    oled_frame_streamer #(
        .WIDTH(8), .HEIGHT(4), .SCLK_DIV(3), .GAP_CYCLES(16)
    ) u_dut_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .pixel_data(pdat[1]),
        .pix_index(pidx[1]), .frame_begin(fb[1]), .sending_pixels(sp[1]),
        .busy(bsy[1]), .cs_n(csn[1]), .sclk(sck[1]), .sdin(sdi[1]), .dc(dcs[1])
    );

    function automatic int dw(int k); return (k == 0) ? 96 : 8; endfunction
    function automatic int dh(int k); return (k == 0) ? 64 : 4; endfunction
    function automatic int dd(int k); return (k == 0) ? 1 : 3;  endfunction
    function automatic int period(int k);
        return 96 * dd(k) + dw(k) * dh(k) * 32 * dd(k) + 16;
    endfunction

    // renderer colour for an index
    function automatic logic [15:0] pix_val(int k, int i);
        return (k == 0) ? 16'(i * 3 + 16'h1234) : 16'(i);
    endfunction

    function automatic logic [7:0] hdr_byte(int k, int j);
        case (j)
            0:       return 8'h15;
            2:       return 8'(dw(k) - 1);
            3:       return 8'h75;
            5:       return 8'(dh(k) - 1);
            default: return 8'h00;
        endcase
    endfunction

    // Expected {cs_n,sclk,sdin,dc,busy,sending,frame_begin,pix_index} from frame position
    function automatic logic [19:0] expect_out(int k, bit run, int t);
        int d, n, cmdl, pixl, bn, tp, wi;
        logic [7:0]  by;
        logic [15:0] w;
        logic cs, sc, sd, dv, fbv;
        logic [12:0] pi;
        d = dd(k); n = dw(k) * dh(k); cmdl = 96 * d; pixl = n * 32 * d;
        cs = 1'b1; sc = 1'b1; sd = 1'b0; dv = 1'b0; fbv = 1'b0; pi = '0;
        if (run && t < cmdl + pixl) begin
            cs = 1'b0;
            sc = ((t % (2 * d)) >= d);
            if (t < cmdl) begin
                bn = t / (2 * d);
                by = hdr_byte(k, bn / 8);
                sd = by[7 - bn % 8];
            end else begin
                tp  = t - cmdl;
                wi  = tp / (32 * d);
                bn  = (tp / (2 * d)) % 16;
                w   = pix_val(k, wi);
                sd  = w[15 - bn];
                dv  = 1'b1;
                fbv = (tp == 0);
                pi  = 13'((wi + 1) % n);
            end
        end
        return {cs, sc, sd, dv, run, dv, fbv, pi};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            pdat[k] <= pix_val(k, int'(pidx[k]));
            if (rst[k]) begin
                m_run[k] <= 1'b0;
            end else if (!m_run[k]) begin
                if (en[k]) begin
                    m_run[k] <= 1'b1;
                    m_t[k]   <= 0;
                end
            end else if (m_t[k] == period(k) - 1) begin
                if (en[k]) m_t[k] <= 0;
                else       m_run[k] <= 1'b0;
            end else begin
                m_t[k] <= m_t[k] + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    task automatic monitor();
        logic [19:0] act;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (chk_en) begin
                    act = {csn[k], sck[k], sdi[k], dcs[k], bsy[k], sp[k], fb[k], pidx[k]};
                    chk($sformatf("cycle%0d_dut%0d", cyc, k), 32'(act),
                        32'(expect_out(k, m_run[k], m_t[k])));
                end
                if (csn[k] === 1'b0) begin
                    if (pcsn[k] === 1'b1) begin
                        frames[k]++;
                        if (k == 0) fall_a = cyc;
                        else        fall_b.push_back(cyc);
                    end
                    if (psck[k] === 1'b0 && sck[k] === 1'b1) begin
                        chk($sformatf("sdin_stable_dut%0d", k), 32'(sdi[k]), 32'(psdi[k]));
                        sh[k] = {sh[k][14:0], sdi[k]};
                        nb[k]++;
                        if (nb[k] == (dcs[k] ? 16 : 8)) begin
                            if (k == 0) dq0.push_back({dcs[k], dcs[k] ? sh[k] : {8'h00, sh[k][7:0]}});
                            else        dq1.push_back({dcs[k], dcs[k] ? sh[k] : {8'h00, sh[k][7:0]}});
                            nb[k] = 0;
                        end
                    end
                end else begin
                    nb[k] = 0;
                end
                psck[k] = sck[k];
                psdi[k] = sdi[k];
                pcsn[k] = csn[k];
            end
        end
    endtask

    initial begin
        logic [16:0] hdr_a[6];
        logic [16:0] hdr_b[6];
        logic [16:0] expw;
        hdr_a = '{17'h00015, 17'h00000, 17'h0005F, 17'h00075, 17'h00000, 17'h0003F};
        hdr_b = '{17'h00015, 17'h00000, 17'h00007, 17'h00075, 17'h00000, 17'h00003};
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; en[k] = 1'b0; frames[k] = 0; nb[k] = 0;
            sh[k] = '0; psck[k] = 1'b1; psdi[k] = 1'b0; pcsn[k] = 1'b1;
        end
        fall_a = 0;
        fork
            monitor();
        join_none

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_csn_a", 32'(csn[0]), 32'd1);
        chk("reset_sclk_a", 32'(sck[0]), 32'd1);
        chk("reset_pix_a", 32'(pidx[0]), 32'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_busy_a", 32'(bsy[0]), 32'd0);
        chk("idle_busy_b", 32'(bsy[1]), 32'd0);
        chk("idle_sdin_a", 32'(sdi[0]), 32'd0);

        // command burst on default-size display
        en[0] = 1'b1;
        for (int i = 0; i < 300 && fb[0] !== 1'b1; i++) @(negedge clk);
        chk("frame_begin_seen_a", 32'(fb[0]), 32'd1);
        chk("frame_begin_latency_a", 32'(cyc - fall_a), 32'd96);
        for (int i = 0; i < 200 && dq0.size() < 8; i++) @(negedge clk);
        chk("decoded_count_a", 32'(dq0.size() >= 8), 32'd1);
        if (dq0.size() >= 8) begin
            for (int j = 0; j < 6; j++) chk($sformatf("cmd_byte%0d_a", j), 32'(dq0[j]), 32'(hdr_a[j]));
            chk("pixel0_a", 32'(dq0[6]), 32'h11234);
            chk("pixel1_a", 32'(dq0[7]), 32'h11237);
        end

        // reset during bit 7 of word 100
        for (int i = 0; i < 4000 && pidx[0] !== 13'd101; i++) @(negedge clk);
        chk("reach_word100_a", 32'(pidx[0]), 32'd101);
        repeat (14) @(negedge clk);
        rst[0] = 1'b1; en[0] = 1'b0;
        @(negedge clk);
        chk("midreset_csn_a", 32'(csn[0]), 32'd1);
        chk("midreset_sclk_a", 32'(sck[0]), 32'd1);
        chk("midreset_pix_a", 32'(pidx[0]), 32'd0);
        rst[0] = 1'b0;
        repeat (5) @(negedge clk);
        dq0.delete();
        en[0] = 1'b1;
        for (int i = 0; i < 400 && dq0.size() < 7; i++) @(negedge clk);
        chk("restart_count_a", 32'(dq0.size() >= 7), 32'd1);
        if (dq0.size() >= 7) begin
            for (int j = 0; j < 6; j++) chk($sformatf("restart_byte%0d_a", j), 32'(dq0[j]), 32'(hdr_a[j]));
            chk("restart_pixel0_a", 32'(dq0[6]), 32'h11234);
        end
        rst[0] = 1'b1; en[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;

        // small display, SCLK_DIV=3: back-to-back frames then disable mid-frame
        en[1] = 1'b1;
        for (int i = 0; i < 12000 && frames[1] < 3; i++) @(negedge clk);
        chk("three_frames_started_b", 32'(frames[1]), 32'd3);
        if (fall_b.size() >= 3) begin
            chk("frame_period1_b", 32'(fall_b[1] - fall_b[0]), 32'd3376);
            chk("frame_period2_b", 32'(fall_b[2] - fall_b[1]), 32'd3376);
        end
        for (int i = 0; i < 4000 && pidx[1] !== 13'd15; i++) @(negedge clk);
        chk("reach_pixel15_b", 32'(pidx[1]), 32'd15);
        en[1] = 1'b0;
        for (int i = 0; i < 4000 && bsy[1] !== 1'b0; i++) @(negedge clk);
        chk("back_to_idle_b", 32'(bsy[1]), 32'd0);
        repeat (300) @(negedge clk);
        chk("no_extra_frame_b", 32'(frames[1]), 32'd3);
        chk("decoded_items_b", 32'(dq1.size()), 32'd114);
        for (int i = 0; i < dq1.size() && i < 114; i++) begin
            expw = ((i % 38) < 6) ? hdr_b[i % 38] : {1'b1, 16'((i % 38) - 6)};
            chk($sformatf("stream_item%0d_b", i), 32'(dq1[i]), 32'(expw));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
